// File: rtl/led_breather_pkg.sv
// Shared phase encoding for the LED breathing generator.
package led_breather_pkg;

  localparam logic [1:0] PH_RAMP_UP   = 2'd0;
  localparam logic [1:0] PH_HOLD_HI   = 2'd1;
  localparam logic [1:0] PH_RAMP_DOWN = 2'd2;
  localparam logic [1:0] PH_HOLD_LO   = 2'd3;

  typedef enum logic [1:0] {
    RAMP_UP   = PH_RAMP_UP,
    HOLD_HI   = PH_HOLD_HI,
    RAMP_DOWN = PH_RAMP_DOWN,
    HOLD_LO   = PH_HOLD_LO
  } phase_t;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter, registered period tick and registered duty comparator.
module led_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                period_end,
  output logic                led,
  output logic                period_tick
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;

  // Last clock of a running PWM period; drives both the tick and the step prescaler.
  assign period_end = en && (pwm_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      led         <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      if (en) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end else begin
        pwm_cnt <= pwm_cnt;
      end
      led         <= en && (pwm_cnt < duty);
      period_tick <= period_end;
    end
  end

endmodule

// File: rtl/led_breather.sv
// Breathing-LED generator: step prescaler, hold counter, ramp FSM and PWM output.
// Optional build macro LED_GAMMA_EN squares the duty for a perceptual brightness curve.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 32,
  parameter int HOLD_STEPS   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase,
  output logic                period_tick
);

  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  if (STEP_PERIODS < 1) begin : g_bad_step_periods
    $error("led_breather: STEP_PERIODS must be >= 1");
  end
  if (HOLD_STEPS < 1) begin : g_bad_hold_steps
    $error("led_breather: HOLD_STEPS must be >= 1");
  end

  logic [STEP_W-1:0]   step_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [PWM_BITS-1:0] duty_raw;
  logic [PWM_BITS-1:0] duty_nxt;
  logic [PWM_BITS-1:0] duty_inc;
  logic [PWM_BITS-1:0] duty_dec;
  phase_t              phase_q;
  phase_t              phase_nxt;
  logic                period_end;
  logic                step_evt;

  assign step_evt = period_end && (step_cnt == STEP_LAST);
  assign duty_inc = duty_raw + PWM_BITS'(1);
  assign duty_dec = duty_raw - PWM_BITS'(1);

  always_comb begin
    phase_nxt = phase_q;
    duty_nxt  = duty_raw;
    hold_nxt  = hold_cnt;
    if (step_evt) begin
      case (phase_q)
        RAMP_UP: begin
          duty_nxt = duty_inc;
          if (duty_inc == DUTY_MAX) begin
            phase_nxt = HOLD_HI;
            hold_nxt  = '0;
          end else begin
            phase_nxt = RAMP_UP;
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            phase_nxt = RAMP_DOWN;
            hold_nxt  = '0;
          end else begin
            hold_nxt  = hold_cnt + HOLD_W'(1);
          end
        end
        RAMP_DOWN: begin
          duty_nxt = duty_dec;
          if (duty_dec == '0) begin
            phase_nxt = HOLD_LO;
            hold_nxt  = '0;
          end else begin
            phase_nxt = RAMP_DOWN;
          end
        end
        HOLD_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            phase_nxt = RAMP_UP;
            hold_nxt  = '0;
          end else begin
            hold_nxt  = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          phase_nxt = RAMP_UP;
          duty_nxt  = '0;
          hold_nxt  = '0;
        end
      endcase
    end else begin
      phase_nxt = phase_q;
    end
  end

  // Duty and phase only move on a step event, which coincides with the PWM wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
      hold_cnt <= '0;
      duty_raw <= '0;
      phase_q  <= RAMP_UP;
    end else begin
      if (period_end) begin
        step_cnt <= step_evt ? '0 : step_cnt + STEP_W'(1);
      end else begin
        step_cnt <= step_cnt;
      end
      hold_cnt <= hold_nxt;
      duty_raw <= duty_nxt;
      phase_q  <= phase_nxt;
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq = {{PWM_BITS{1'b0}}, duty_raw} * {{PWM_BITS{1'b0}}, duty_raw};
  assign duty    = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty = duty_raw;
`endif

  assign phase = phase_q;

  led_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .duty       (duty),
    .period_end (period_end),
    .led        (led),
    .period_tick(period_tick)
  );

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench: expected outputs come from a model indexed by enabled-cycle count.
module tb_led_breather;

  localparam int PB   = 4;
  localparam int SP   = 2;
  localparam int H    = 3;
  localparam int P    = 1 << PB;
  localparam int DMAX = P - 1;
  localparam int CYC  = 2 * DMAX + 2 * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          led;
  logic [PB-1:0] duty;
  logic [1:0]    phase;
  logic          period_tick;

  typedef struct {
    int led;
    int tick;
    int duty;
    int phase;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   t      = 0;

  always #5 clk = ~clk;

  led_breather #(
    .PWM_BITS    (PB),
    .STEP_PERIODS(SP),
    .HOLD_STEPS  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .led        (led),
    .duty       (duty),
    .phase      (phase),
    .period_tick(period_tick)
  );

  // Position inside one breath, counted in duty steps.
  function automatic int k_of(int tt);
    return ((tt / P) / SP) % CYC;
  endfunction

  function automatic int phase_of(int tt);
    int k = k_of(tt);
    if (k < DMAX) return 0;
    if (k < DMAX + H) return 1;
    if (k < 2 * DMAX + H) return 2;
    return 3;
  endfunction

  function automatic int raw_of(int tt);
    int k = k_of(tt);
    if (k < DMAX) return k;
    if (k < DMAX + H) return DMAX;
    if (k < 2 * DMAX + H) return 2 * DMAX + H - k;
    return 0;
  endfunction

  function automatic int duty_of(int tt);
`ifdef LED_GAMMA_EN
    return (raw_of(tt) * raw_of(tt)) >> PB;
`else
    return raw_of(tt);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    if (r) begin
      t = 0;
      x.led = 0;
      x.tick = 0;
    end else if (e) begin
      x.led  = ((t % P) < duty_of(t)) ? 1 : 0;
      x.tick = ((t % P) == P - 1) ? 1 : 0;
      t++;
    end else begin
      x.led = 0;
      x.tick = 0;
    end
    x.duty  = duty_of(t);
    x.phase = phase_of(t);
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("led", {31'd0, led}, x.led);
        check("period_tick", {31'd0, period_tick}, x.tick);
        check("duty", {{(32-PB){1'b0}}, duty}, x.duty);
        check("phase", {30'd0, phase}, x.phase);
      end
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) drive(1'b1, 1'b1);
    repeat (CYC * SP * P + 40) drive(1'b0, 1'b1);

    n = 0;
    while (phase_of(t) != 2 && n < 5000) begin
      drive(1'b0, 1'b1);
      n++;
    end
    repeat (7) drive(1'b0, 1'b1);
    repeat (100) drive(1'b0, 1'b0);
    repeat (300) drive(1'b0, 1'b1);

    n = 0;
    while (phase_of(t) != 1 && n < 5000) begin
      drive(1'b0, 1'b1);
      n++;
    end
    repeat (5) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (600) drive(1'b0, 1'b1);

    repeat (3000) drive($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
